// File: rtl/wb_regfile.sv
// Write-back pipeline register (M->W) merged with the Y86-64 register file.
// Commits valE/valM, bypasses the pending write-back to decode, and halts on the first exception.
module wb_regfile #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m_valid,
   input  logic [1:0]        m_stat,
   input  logic [3:0]        m_icode,
   input  logic [3:0]        m_dstE,
   input  logic [3:0]        m_dstM,
   input  logic [DATA_W-1:0] m_valE,
   input  logic [DATA_W-1:0] m_valM,
   input  logic              w_stall,
   input  logic              w_bubble,
   input  logic [3:0]        srcA,
   input  logic [3:0]        srcB,
   output logic [DATA_W-1:0] valA_o,
   output logic [DATA_W-1:0] valB_o,
   output logic [1:0]        w_stat_o,
   output logic              halted_o,
   output logic [CNT_W-1:0]  retired_o
);

   localparam logic [3:0] REG_NONE  = 4'hF;
   localparam logic [1:0] STAT_AOK  = 2'd0;
   localparam logic [3:0] ICODE_NOP = 4'h1;

   logic              w_valid_q, w_valid_d;
   logic [1:0]        w_stat_q,  w_stat_d;
   logic [3:0]        w_icode_q, w_icode_d;
   logic [3:0]        w_dst_e_q, w_dst_e_d;
   logic [3:0]        w_dst_m_q, w_dst_m_d;
   logic [DATA_W-1:0] w_val_e_q, w_val_e_d;
   logic [DATA_W-1:0] w_val_m_q, w_val_m_d;

   logic [DATA_W-1:0] regs_q [15];
   logic [DATA_W-1:0] regs_d [15];

   logic              halted_q,  halted_d;
   logic [1:0]        hstat_q,   hstat_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   logic              commit;
   logic              exc_entry;
   logic              byp_ok;
   logic              unused_icode;

   assign commit    = w_valid_q && (w_stat_q == STAT_AOK) && !w_stall && !halted_q;
   assign exc_entry = w_valid_q && (w_stat_q != STAT_AOK) && !w_stall && !halted_q;
   // A stalled W still bypasses: its value is architecturally pending, just not yet written.
   assign byp_ok    = w_valid_q && (w_stat_q == STAT_AOK) && !halted_q;

   assign unused_icode = ^w_icode_q;

   function automatic logic [DATA_W-1:0] read_port(input logic [3:0] src);
      logic [DATA_W-1:0] val;
      val = '0;
      if (src == REG_NONE) begin
         val = '0;
      end else if (byp_ok && (src == w_dst_m_q)) begin
         val = w_val_m_q;
      end else if (byp_ok && (src == w_dst_e_q)) begin
         val = w_val_e_q;
      end else begin
         val = regs_q[src];
      end
      return val;
   endfunction

   always_comb begin
      valA_o = read_port(srcA);
      valB_o = read_port(srcB);
   end

   always_comb begin
      w_valid_d = w_valid_q;
      w_stat_d  = w_stat_q;
      w_icode_d = w_icode_q;
      w_dst_e_d = w_dst_e_q;
      w_dst_m_d = w_dst_m_q;
      w_val_e_d = w_val_e_q;
      w_val_m_d = w_val_m_q;
      // Once halted nothing may reach W again, regardless of stall.
      if (halted_q || (!w_stall && (w_bubble || !m_valid))) begin
         w_valid_d = 1'b0;
         w_stat_d  = STAT_AOK;
         w_icode_d = ICODE_NOP;
         w_dst_e_d = REG_NONE;
         w_dst_m_d = REG_NONE;
         w_val_e_d = '0;
         w_val_m_d = '0;
      end else if (!w_stall) begin
         w_valid_d = 1'b1;
         w_stat_d  = m_stat;
         w_icode_d = m_icode;
         w_dst_e_d = m_dstE;
         w_dst_m_d = m_dstM;
         w_val_e_d = m_valE;
         w_val_m_d = m_valM;
      end
   end

   always_comb begin
      regs_d    = regs_q;
      retired_d = retired_q;
      halted_d  = halted_q;
      hstat_d   = hstat_q;
      if (commit) begin
         if (w_dst_e_q != REG_NONE) begin
            regs_d[w_dst_e_q] = w_val_e_q;
         end
         // Applied after valE so popq %rsp leaves the popped value in the register.
         if (w_dst_m_q != REG_NONE) begin
            regs_d[w_dst_m_q] = w_val_m_q;
         end
         retired_d = retired_q + 1'b1;
      end
      if (exc_entry) begin
         halted_d = 1'b1;
         hstat_d  = w_stat_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_valid_q <= 1'b0;
         w_stat_q  <= STAT_AOK;
         w_icode_q <= ICODE_NOP;
         w_dst_e_q <= REG_NONE;
         w_dst_m_q <= REG_NONE;
         w_val_e_q <= '0;
         w_val_m_q <= '0;
         for (int i = 0; i < 15; i++) begin
            regs_q[i] <= '0;
         end
         halted_q  <= 1'b0;
         hstat_q   <= STAT_AOK;
         retired_q <= '0;
      end else begin
         w_valid_q <= w_valid_d;
         w_stat_q  <= w_stat_d;
         w_icode_q <= w_icode_d;
         w_dst_e_q <= w_dst_e_d;
         w_dst_m_q <= w_dst_m_d;
         w_val_e_q <= w_val_e_d;
         w_val_m_q <= w_val_m_d;
         regs_q    <= regs_d;
         halted_q  <= halted_d;
         hstat_q   <= hstat_d;
         retired_q <= retired_d;
      end
   end

   assign w_stat_o  = halted_q ? hstat_q : (w_valid_q ? w_stat_q : STAT_AOK);
   assign halted_o  = halted_q;
   assign retired_o = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus random traffic against an array-based reference model.
module tb_wb_regfile;

   localparam int DW = 64;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m_valid;
   logic [1:0]    m_stat;
   logic [3:0]    m_icode, m_dstE, m_dstM;
   logic [DW-1:0] m_valE, m_valM;
   logic          w_stall, w_bubble;
   logic [3:0]    srcA, srcB;
   logic [DW-1:0] valA_o, valB_o;
   logic [1:0]    w_stat_o;
   logic          halted_o;
   logic [CW-1:0] retired_o;

   int checks   = 0;
   int failures = 0;

   // Reference model state: what the architecture holds, plus the single pending W instruction.
   logic [DW-1:0] mregs [15];
   bit            wv;
   bit [1:0]      wst;
   bit [3:0]      wde, wdm;
   bit [DW-1:0]   wve, wvm;
   bit            mh;
   bit [1:0]      mls;
   int            mret;

   always #5 clk = ~clk;

   wb_regfile #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_stat(m_stat), .m_icode(m_icode),
      .m_dstE(m_dstE), .m_dstM(m_dstM), .m_valE(m_valE), .m_valM(m_valM),
      .w_stall(w_stall), .w_bubble(w_bubble), .srcA(srcA), .srcB(srcB),
      .valA_o(valA_o), .valB_o(valB_o), .w_stat_o(w_stat_o), .halted_o(halted_o),
      .retired_o(retired_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mread(input logic [3:0] s);
      bit elig;
      elig = wv && (wst == 2'd0) && !mh;
      if (s == 4'hF) return '0;
      if (elig && s == wdm) return wvm;
      if (elig && s == wde) return wve;
      return mregs[s];
   endfunction

   task automatic mstep();
      bit was_halted;
      bit active;
      if (!rst_n) begin
         for (int i = 0; i < 15; i++) mregs[i] = '0;
         wv = 0; wst = 0; wde = 4'hF; wdm = 4'hF; wve = '0; wvm = '0;
         mh = 0; mls = 0; mret = 0;
         return;
      end
      was_halted = mh;
      active = wv && !w_stall && !mh;
      if (active && wst == 2'd0) begin
         if (wde != 4'hF) mregs[wde] = wve;
         if (wdm != 4'hF) mregs[wdm] = wvm;
         mret = (mret + 1) % (1 << CW);
      end else if (active) begin
         mh  = 1;
         mls = wst;
      end
      if (was_halted || (!w_stall && (w_bubble || !m_valid))) begin
         wv = 0; wst = 0; wde = 4'hF; wdm = 4'hF; wve = '0; wvm = '0;
      end else if (!w_stall) begin
         wv = 1; wst = m_stat; wde = m_dstE; wdm = m_dstM; wve = m_valE; wvm = m_valM;
      end
   endtask

   task automatic check_all();
      check("valA", valA_o, mread(srcA));
      check("valB", valB_o, mread(srcB));
      check("w_stat", w_stat_o, mh ? mls : (wv ? wst : 2'd0));
      check("halted", halted_o, mh);
      check("retired", retired_o, mret);
   endtask

   task automatic step();
      #1;
      check_all();
      @(posedge clk);
      mstep();
      #1;
   endtask

   task automatic idle();
      m_valid = 0; m_stat = 0; m_icode = 4'h1; m_dstE = 4'hF; m_dstM = 4'hF;
      m_valE = '0; m_valM = '0; w_stall = 0; w_bubble = 0; srcA = 4'hF; srcB = 4'hF;
   endtask

   task automatic issue(input bit [1:0] st, input bit [3:0] de, input bit [DW-1:0] ve,
                        input bit [3:0] dm, input bit [DW-1:0] vm);
      m_valid = 1; m_stat = st; m_icode = 4'h3; m_dstE = de; m_valE = ve; m_dstM = dm; m_valM = vm;
   endtask

   initial begin
      idle();
      rst_n = 0;
      repeat (2) @(posedge clk);
      mstep();
      #1;
      rst_n = 1;
      check("rst_retired", retired_o, 0);
      check("rst_halted", halted_o, 0);
      check("rst_stat", w_stat_o, 0);
      check("rst_srcF", valA_o, 0);

      // irmovq to %rbx: bypass first, then the committed register
      issue(0, 4'd3, 64'h1234, 4'hF, 0);
      step();
      idle(); srcA = 4'd3;
      #1 check("irm_bypass", valA_o, 64'h1234);
      step();
      check("irm_reg", valA_o, 64'h1234);
      check("irm_retired", retired_o, 1);

      // popq %rsp: valM must win both on bypass and in the register
      issue(0, 4'd4, 64'h100, 4'd4, 64'hBEEF); srcB = 4'd4;
      step();
      idle(); srcB = 4'd4;
      #1 check("pop_bypass", valB_o, 64'hBEEF);
      step();
      check("pop_reg", valB_o, 64'hBEEF);
      check("pop_retired", retired_o, 2);

      // stall with simultaneous bubble: W holds, nothing commits
      issue(0, 4'd2, 64'd7, 4'hF, 0);
      step();
      issue(0, 4'd2, 64'd99, 4'hF, 0); w_stall = 1; w_bubble = 1; srcA = 4'd2;
      for (int i = 0; i < 3; i++) begin
         #1 check("stall_bypass", valA_o, 64'd7);
         check("stall_retired", retired_o, 2);
         step();
      end
      idle(); srcA = 4'd2;
      step();
      check("stall_reg", valA_o, 64'd7);
      check("stall_retired_once", retired_o, 3);
      step();
      check("stall_retired_hold", retired_o, 3);

      // exception: ADR write to 5 is dropped, the following write to 6 never commits
      issue(0, 4'd5, 64'h55, 4'd6, 64'h66);
      step();
      issue(2'd2, 4'hF, 0, 4'd5, 64'd9);
      step();
      issue(0, 4'd6, 64'h77, 4'hF, 0);
      step();
      idle(); srcA = 4'd5; srcB = 4'd6;
      #1 check("exc_halted", halted_o, 1);
      check("exc_stat", w_stat_o, 2);
      check("exc_reg5", valA_o, 64'h55);
      check("exc_reg6", valB_o, 64'h66);
      check("exc_retired", retired_o, 4);

      // reset while halted with a valid instruction still in W
      rst_n = 0; srcA = 4'hF;
      step();
      rst_n = 1;
      check("rst2_halted", halted_o, 0);
      check("rst2_stat", w_stat_o, 0);
      check("rst2_retired", retired_o, 0);
      check("rst2_srcF", valA_o, 0);
      srcB = 4'd5;
      #1 check("rst2_reg5", valB_o, 0);

      // second exception (INS): status stays latched across idle cycles
      issue(2'd3, 4'd1, 64'h11, 4'hF, 0);
      step();
      idle(); srcA = 4'd1;
      for (int i = 0; i < 3; i++) step();
      check("ins_stat_held", w_stat_o, 3);
      check("ins_reg1", valA_o, 0);
      rst_n = 0;
      step();
      rst_n = 1;

      // counter wrap at 2^CW
      for (int i = 1; i <= (1 << CW); i++) begin
         issue(0, 4'd1, i, 4'hF, 0);
         step();
         idle();
         step();
         if (i == (1 << CW) - 1) check("wrap_max", retired_o, (1 << CW) - 1);
      end
      check("wrap_zero", retired_o, 0);

      // random traffic against the model
      begin
         int halt_cycles;
         halt_cycles = 0;
         for (int n = 0; n < 3000; n++) begin
            rst_n    = ($urandom_range(0, 79) != 0) && (halt_cycles < 8);
            m_valid  = ($urandom_range(0, 3) != 0);
            m_stat   = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            m_icode  = 4'($urandom_range(0, 11));
            m_dstE   = 4'($urandom_range(0, 15));
            m_dstM   = ($urandom_range(0, 2) == 0) ? m_dstE : 4'($urandom_range(0, 15));
            m_valE   = {$urandom, $urandom};
            m_valM   = {$urandom, $urandom};
            w_stall  = ($urandom_range(0, 5) == 0);
            w_bubble = ($urandom_range(0, 5) == 0);
            srcA     = 4'($urandom_range(0, 15));
            srcB     = ($urandom_range(0, 1) == 0) ? m_dstE : 4'($urandom_range(0, 15));
            step();
            halt_cycles = mh ? halt_cycles + 1 : 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Combined write-back pipeline register (M→W) and Y86-64 register file for the pipelined core.
- Captures memory-stage results, commits valE/valM to the 15 program registers, and serves the decode stage's two read ports with write-back bypass.
- Tracks architectural status: the first non-AOK instruction reaching write-back halts all further commits.
- Keeps a retired-instruction counter.

Parameters:
- DATA_W, 64, register/data width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- m_valid  in  1  memory stage holds a real instruction
- m_stat  in  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS
- m_icode  in  4  instruction code
- m_dstE  in  4  valE destination (0xF = none)
- m_dstM  in  4  valM destination (0xF = none)
- m_valE  in  DATA_W  ALU result
- m_valM  in  DATA_W  memory read data
- w_stall  in  1  hold W register, suppress commit
- w_bubble  in  1  load bubble into W
- srcA  in  4  decode read index A (0xF = none)
- srcB  in  4  decode read index B
- valA_o  out  DATA_W  read data A
- valB_o  out  DATA_W  read data B
- w_stat_o  out  2  architectural status
- halted_o  out  1  sticky halt
- retired_o  out  CNT_W  committed-instruction count

Behaviour:
- Reset (rst_n low at posedge):
  - regs[0..14] = 0; W register = bubble (valid 0, icode 1/NOP, dstE = dstM = 0xF, stat AOK, vals 0).
  - halted_o = 0, w_stat_o = AOK (0), retired_o = 0.
  - Reset asserted mid-operation discards the W contents and any pending commit that cycle.
- W register load at posedge:
  - w_stall = 1: hold.
  - Else w_bubble = 1 or m_valid = 0: load bubble.
  - Else: load the m_* fields.
  - Stall has priority over bubble. While halted_o = 1, W always loads bubble.
- commit = W.valid & W.stat==AOK & !w_stall & !halted_o.
- On a commit cycle, at posedge:
  - regs[W.dstE] <= W.valE if dstE != 0xF.
  - regs[W.dstM] <= W.valM if dstM != 0xF.
  - dstE == dstM (popq %rsp): valM wins.
  - retired_o <= retired_o + 1; wraps at 2^CNT_W silently.
- Exception entry: when W.valid & W.stat != AOK & !w_stall & !halted_o:
  - no register writes, no retire increment;
  - halted_o <= 1 and the status is latched.
  - Only reset clears halt.
- w_stat_o (combinational):
  - halted_o = 1: the latched status.
  - Else W.valid: W.stat.
  - Else: AOK.
- Reads are combinational, zero latency; each port evaluates in priority order:
  - src == 0xF → 0.
  - src == W.dstM and bypass-eligible → W.valM.
  - src == W.dstE and bypass-eligible → W.valE.
  - Else regs[src].
  - Bypass-eligible = W.valid & W.stat==AOK & !halted_o. Stall does not disable bypass, since the value is still pending.
- Index 0xF is never written. regs has exactly 15 entries.

Test Plan:
- Reset, then irmovq path (m_valid = 1, stat AOK, dstE = 3, valE = 0x1234, dstM = F), one cycle → same cycle srcA = 3 gives 0x1234 via bypass. Next cycle regs[3] = 0x1234 and retired_o = 1.
- popq %rsp: dstE = 4, valE = 0x100, dstM = 4, valM = 0xBEEF → srcB = 4 gives 0xBEEF both before and after commit; regs[4] = 0xBEEF.
- Load dstE = 2, valE = 7 with w_stall = 1 for 3 cycles, and w_bubble = 1 in the same cycles → W held, bypass gives 7, regs[2] unchanged, retired_o unchanged. Release → regs[2] = 7, retired_o += 1 exactly once.
- Inject stat = ADR, dstM = 5, valM = 9, then an AOK write to reg 6 → regs[5] and regs[6] unchanged, halted_o = 1, w_stat_o = 2 held. Bypass to 5 and 6 returns the old values.
- retired_o preset near max (2^CNT_W − 1 commits, or CNT_W = 4 build) → next commit wraps it to 0.
- Assert rst_n low while halted with W valid → all regs 0, halted_o = 0, w_stat_o = 0, retired_o = 0. srcA = F gives 0 throughout.
